// File: rtl/button_step_pulser.sv
// -----------------------------------------------------------------------------
// button_step_pulser
//
// Purpose:
//   Turns the two raw board push-buttons (UP, DOWN) into clean, single-cycle
//   step strobes for the colour-select mod-N counter. Each button channel is
//   synchronized, debounced, edge-detected and optionally auto-repeated while
//   held. Every output is a registered function of state clocked by C, so the
//   counter downstream never sees a raw button level as a clock.
//
// Ports:
//   C       in   system clock, all logic on posedge
//   R       in   synchronous active-high reset
//   BTN_UP  in   raw asynchronous UP button, active-high
//   BTN_DN  in   raw asynchronous DOWN button, active-high
//   UP_P    out  one-cycle increment strobe
//   DN_P    out  one-cycle decrement strobe
//   UP_LVL  out  debounced UP level
//   DN_LVL  out  debounced DOWN level
//
// Lane 0 is UP, lane 1 is DOWN. Both lanes run the identical pipeline:
//   2-flop sync -> debounce counter -> stable level -> pulse FSM.
// -----------------------------------------------------------------------------
module button_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic C,
  input  logic R,
  input  logic BTN_UP,
  input  logic BTN_DN,
  output logic UP_P,
  output logic DN_P,
  output logic UP_LVL,
  output logic DN_LVL
);

  localparam int NUM_LANES = 2;

  // Terminal counts; counters stop at these so they never wrap.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [NUM_LANES-1:0] btn;

  // Synchronizer
  logic [NUM_LANES-1:0] s1_q, s1_d;
  logic [NUM_LANES-1:0] s2_q, s2_d;

  // Debounce
  logic [NUM_LANES-1:0]            stable_q, stable_d;
  logic [NUM_LANES-1:0]            prev_q, prev_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  // Pulse FSM
  state_e                          state_q [NUM_LANES];
  state_e                          state_d [NUM_LANES];
  logic [NUM_LANES-1:0][CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [NUM_LANES-1:0]            p_q, p_d;

  logic conflict;

  assign btn = {BTN_DN, BTN_UP};

  // Both debounced levels high: neither button may step the counter.
  assign conflict = &stable_q;

  // ---------------------------------------------------------------------------
  // Synchronizer + debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      s1_d[i]     = btn[i];
      s2_d[i]     = s1_q[i];
      prev_d[i]   = stable_q[i];
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = db_cnt_q[i];

      // The count only survives while s2 keeps disagreeing with the stable
      // level; a single agreeing cycle restarts it, so short glitches die here.
      if (s2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse FSM: press pulse on the registered 0->1 of stable, then optional
  // auto-repeat. IDLE with stable still high acts as the blocked state: the
  // rise detector cannot fire again until the level has dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      p_d[i]       = 1'b0;

      if (!stable_q[i] || conflict) begin
        // Release or conflict: drop back, no pulse. A rise landing here while
        // the other level is high is lost, which is intended.
        state_d[i]   = ST_IDLE;
        rep_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (stable_q[i] && !prev_q[i]) begin
              p_d[i]       = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = (REPEAT_EN != 0) ? ST_DELAY : ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (rep_cnt_q[i] == RD_LAST) begin
              p_d[i]       = 1'b1;
              rep_cnt_d[i] = '0;
              state_d[i]   = ST_REPEAT;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (rep_cnt_q[i] == RP_LAST) begin
              p_d[i]       = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rep_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (R) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      p_q       <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      p_q       <= p_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The strobe is masked by the live conflict term as well, so a
  // pulse registered on the same edge the other level rises never escapes;
  // this also guarantees UP_P and DN_P are never high together.
  // ---------------------------------------------------------------------------
  assign UP_LVL = stable_q[0];
  assign DN_LVL = stable_q[1];
  assign UP_P   = p_q[0] & ~conflict;
  assign DN_P   = p_q[1] & ~conflict;

endmodule

// File: tb/tb_button_step_pulser.sv
// -----------------------------------------------------------------------------
// tb_button_step_pulser
//
// Two DUTs share the stimulus: dut0 with auto-repeat, dut1 with one pulse per
// press. A reference model (debounce as a run-length rule, pulse timing as
// arithmetic on the time since the press) pushes expected outputs into a queue
// on each clock edge; a monitor on the falling edge pops and compares.
// Directed sections add pulse-count and latency checks.
// -----------------------------------------------------------------------------
module tb_button_step_pulser;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic [1:0] up_p, dn_p, up_lvl, dn_lvl;

  always #5 clk = ~clk;

  button_step_pulser #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                       .REPEAT_PERIOD(RP), .CNT_W(8)) dut0 (
    .C(clk), .R(rst), .BTN_UP(btn_up), .BTN_DN(btn_dn),
    .UP_P(up_p[0]), .DN_P(dn_p[0]), .UP_LVL(up_lvl[0]), .DN_LVL(dn_lvl[0]));

  button_step_pulser #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                       .REPEAT_PERIOD(RP), .CNT_W(8)) dut1 (
    .C(clk), .R(rst), .BTN_UP(btn_up), .BTN_DN(btn_dn),
    .UP_P(up_p[1]), .DN_P(dn_p[1]), .UP_LVL(up_lvl[1]), .DN_LVL(dn_lvl[1]));

  typedef struct packed {
    logic up_p;
    logic dn_p;
    logic up_lvl;
    logic dn_lvl;
  } out_t;

  out_t q0[$];
  out_t q1[$];
  out_t exp_last [2];

  int checks = 0;
  int errors = 0;
  int up_cnt [2];
  int dn_cnt [2];

  // ---------------------------------------------------------------------------
  // Reference model, indexed [dut][channel]
  // ---------------------------------------------------------------------------
  bit m_s1   [2][2];
  bit m_s2   [2][2];
  bit m_st   [2][2];
  bit m_prev [2][2];
  bit m_preg [2][2];
  int m_run  [2][2];
  int m_press[2][2];   // edge index of the press pulse, -1 when not armed
  int ecnt = 0;

  always @(posedge clk) begin
    bit ob_s1 [2];
    bit ob_s2 [2];
    bit ob_st [2];
    bit ob_pv [2];
    bit bt [2];
    bit conf;
    bit pulse;
    bit both;
    int dlt;
    out_t e;
    bt[0] = btn_up;
    bt[1] = btn_dn;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_st[d][c] = 1'b0;
          m_prev[d][c] = 1'b0; m_preg[d][c] = 1'b0;
          m_run[d][c] = 0; m_press[d][c] = -1;
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          ob_s1[c] = m_s1[d][c]; ob_s2[c] = m_s2[d][c];
          ob_st[c] = m_st[d][c]; ob_pv[c] = m_prev[d][c];
        end
        conf = ob_st[0] & ob_st[1];
        for (int c = 0; c < 2; c++) begin
          pulse = 1'b0;
          if (!ob_st[c] || conf) begin
            m_press[d][c] = -1;
          end else if (!ob_pv[c]) begin
            m_press[d][c] = ecnt;
            pulse = 1'b1;
          end else if (m_press[d][c] >= 0 && d == 0) begin
            dlt = ecnt - m_press[d][c];
            if (dlt == RD || (dlt > RD && (dlt - RD) % RP == 0)) pulse = 1'b1;
          end
          // Stable level flips once s2 has disagreed for DB edges in a row.
          if (ob_s2[c] != ob_st[c]) begin
            m_run[d][c] = m_run[d][c] + 1;
            if (m_run[d][c] == DB) begin
              m_st[d][c] = ob_s2[c];
              m_run[d][c] = 0;
            end
          end else begin
            m_run[d][c] = 0;
          end
          m_prev[d][c] = ob_st[c];
          m_s2[d][c]   = ob_s1[c];
          m_s1[d][c]   = bt[c];
          m_preg[d][c] = pulse;
        end
      end
      both     = m_st[d][0] & m_st[d][1];
      e.up_lvl = m_st[d][0];
      e.dn_lvl = m_st[d][1];
      e.up_p   = m_preg[d][0] & ~both;
      e.dn_p   = m_preg[d][1] & ~both;
      exp_last[d] = e;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    ecnt++;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    out_t e;
    out_t a;
    bit empty;
    for (int d = 0; d < 2; d++) begin
      a = {up_p[d], dn_p[d], up_lvl[d], dn_lvl[d]};
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      checks++;
      if (empty) begin
        errors++;
        $display("FAIL sb_empty dut%0d t=%0t: no expected entry for got %b", d, $time, a);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outs dut%0d t=%0t: got {up_p,dn_p,up_lvl,dn_lvl}=%b expected %b",
                   d, $time, a, e);
        end
      end
      checks++;
      if (a.up_p === 1'b1 && a.dn_p === 1'b1) begin
        errors++;
        $display("FAIL exclusive dut%0d t=%0t: got up_p=1 dn_p=1 expected not both", d, $time);
      end
      if (a.up_p === 1'b1) up_cnt[d]++;
      if (a.dn_p === 1'b1) dn_cnt[d]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int su [2];
    int sd [2];
    int n;
    bit found;

    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // 1. clean press/release
    su = up_cnt; sd = dn_cnt;
    btn_up = 1'b1; cyc(6); btn_up = 1'b0; cyc(15);
    chk("t1_up_pulses_dut0", up_cnt[0] - su[0], 1);
    chk("t1_up_pulses_dut1", up_cnt[1] - su[1], 1);
    chk("t1_dn_pulses_dut0", dn_cnt[0] - sd[0], 0);

    // 2. glitch rejection
    sd = dn_cnt;
    btn_dn = 1'b1; cyc(3); btn_dn = 1'b0; cyc(1);
    btn_dn = 1'b1; cyc(3); btn_dn = 1'b0; cyc(12);
    chk("t2_dn_pulses_dut0", dn_cnt[0] - sd[0], 0);
    chk("t2_dn_lvl_dut0", int'(dn_lvl[0]), 0);

    // 3. auto-repeat: pulses at +0, +10, +13, ... while stable is high
    su = up_cnt;
    btn_up = 1'b1; cyc(40); btn_up = 1'b0; cyc(20);
    chk("t3_repeat_dut0", up_cnt[0] - su[0], 11);
    chk("t3_norepeat_dut1", up_cnt[1] - su[1], 1);

    // 4. conflict, then clean DN press
    sd = dn_cnt;
    btn_up = 1'b1; cyc(20);
    btn_dn = 1'b1; cyc(20);
    btn_up = 1'b0; btn_dn = 1'b0; cyc(15);
    chk("t4_conflict_dn_dut0", dn_cnt[0] - sd[0], 0);
    chk("t4_conflict_dn_dut1", dn_cnt[1] - sd[1], 0);
    sd = dn_cnt;
    btn_dn = 1'b1; cyc(8); btn_dn = 1'b0; cyc(15);
    chk("t4_dn_alone_dut0", dn_cnt[0] - sd[0], 1);
    chk("t4_dn_alone_dut1", dn_cnt[1] - sd[1], 1);

    // 5. reset in REPEAT with the button still held
    btn_up = 1'b1; cyc(25);
    rst = 1'b1; cyc(1);
    chk("t5_clear_dut0", int'({up_p[0], dn_p[0], up_lvl[0], dn_lvl[0]}), 0);
    chk("t5_clear_dut1", int'({up_p[1], dn_p[1], up_lvl[1], dn_lvl[1]}), 0);
    rst = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 50) begin
      cyc(1);
      n++;
      if (up_p[0] === 1'b1) found = 1'b1;
    end
    chk("t5_relatency", n, DB + 3);
    btn_up = 1'b0; cyc(20);

    // 6. reset pulse between edges must not change anything
    btn_up = 1'b1; cyc(10);
    #1 rst = 1'b1;
    #2;
    chk("t6_sync_dut0", int'({up_p[0], dn_p[0], up_lvl[0], dn_lvl[0]}), int'(exp_last[0]));
    chk("t6_sync_dut1", int'({up_p[1], dn_p[1], up_lvl[1], dn_lvl[1]}), int'(exp_last[1]));
    chk("t6_lvl_held", int'(up_lvl[0]), 1);
    rst = 1'b0;
    cyc(1);
    btn_up = 1'b0; cyc(15);

    // Random phase: scoreboard checks every cycle
    for (int s = 0; s < 40; s++) begin
      btn_up = 1'($urandom_range(0, 1));
      btn_dn = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 19) == 0);
      cyc(1);
      rst = 1'b0;
      cyc(int'($urandom_range(0, 24)));
    end
    btn_up = 1'b0; btn_dn = 1'b0;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
